// File: rtl/uart_rx_capture_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_capture_buffer
//
// One receive channel of the bench UART checker. The serial line is
// synchronised, oversampled at DIV = G_CLOCK_FREQ / G_BAUDRATE clocks per bit,
// deserialised and stored in a circular buffer that the sequencer drains
// through a simple read port. Error and overflow status are sticky.
//
// Ports
//   clk           bench clock
//   rst_n         asynchronous reset, active HIGH (legacy name kept)
//   i_rx          serial line, asynchronous to clk
//   i_enable      gates detection of new start bits only
//   i_flush       empties the buffer (pointers and count to 0)
//   i_clr_err     clears the sticky status flags
//   i_rd_en       read request; honoured only when the buffer is not empty
//   o_rd_data     read word, valid one cycle after an honoured request
//   o_rd_valid    one-cycle pulse qualifying o_rd_data
//   o_count       number of stored words
//   o_empty       o_count == 0
//   o_full        o_count == depth
//   o_rx_done     one-cycle pulse per frame with good stop bit(s)
//   o_parity_err  sticky: a frame failed its parity check
//   o_frame_err   sticky: a frame had a bad stop bit
//   o_overflow    sticky: a good frame arrived while the buffer was full
//   o_dbg_state   current receiver FSM state (debug/observation)
//
// Handshake: the read port has no back-pressure. A request in cycle N with
// count > 0 produces o_rd_valid=1 and the word in cycle N+1; a request while
// empty is dropped and o_rd_data keeps its previous value.
// ---------------------------------------------------------------------------
module uart_rx_capture_buffer #(
    parameter int G_CLOCK_FREQ        = 20000000,
    parameter int G_BAUDRATE          = 2000000,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_PARITY            = 0,
    parameter int G_STOP_BIT_NUMBER   = 1,
    parameter int G_FIRST_BIT         = 0,
    parameter int G_POLARITY          = 1,
    parameter int G_BUFFER_ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_rx,
    input  logic                         i_enable,
    input  logic                         i_flush,
    input  logic                         i_clr_err,
    input  logic                         i_rd_en,
    output logic [G_DATA_WIDTH-1:0]      o_rd_data,
    output logic                         o_rd_valid,
    output logic [G_BUFFER_ADDR_WIDTH:0] o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_rx_done,
    output logic                         o_parity_err,
    output logic                         o_frame_err,
    output logic                         o_overflow,
    output logic [2:0]                   o_dbg_state
);

    localparam int W     = G_DATA_WIDTH;
    localparam int AW    = G_BUFFER_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int DIV   = G_CLOCK_FREQ / G_BAUDRATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(W - 1);
    localparam logic [3:0]       LAST_STOP = 4'(G_STOP_BIT_NUMBER - 1);
    localparam logic             IDLE_LVL  = 1'(G_POLARITY);
    localparam logic             START_LVL = ~IDLE_LVL;
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [AW:0]      COUNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]      DEPTH_C   = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STORE  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser, preset to the idle level so reset never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, rx_s;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [W-1:0]     shift_q, shift_d;
    logic             par_q, par_d;
    logic             frm_q, frm_d;
    logic             tick;
    logic             exp_par;

    assign tick = (cnt_q == '0);

    // Parity bit the transmitter should have sent for the received data.
    assign exp_par = (G_PARITY == 2) ? ~(^shift_q) : (^shift_q);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        frm_d   = frm_q;

        case (state_q)
            S_IDLE: begin
                if (i_enable && (rx_s == START_LVL)) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                    par_d   = 1'b0;
                    frm_d   = 1'b0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (rx_s == START_LVL) begin
                        state_d = S_DATA;
                        cnt_d   = DIV_M1;
                        bit_d   = '0;
                    end else begin
                        // Too short to be a start bit.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (G_FIRST_BIT == 0) begin
                        shift_d = {rx_s, shift_q[W-1:1]};
                    end else begin
                        shift_d = {shift_q[W-2:0], rx_s};
                    end
                    cnt_d = DIV_M1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (G_PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_PARITY: begin
                if (tick) begin
                    if (rx_s != exp_par) begin
                        par_d = 1'b1;
                    end
                    cnt_d   = DIV_M1;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (rx_s != IDLE_LVL) begin
                        frm_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        state_d = S_STORE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        cnt_d = DIV_M1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_STORE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_dbg_state = state_q;

    // ------------------------------------------------------------------
    // Circular buffer, read port and status
    // ------------------------------------------------------------------
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rd_data_q;
    logic          rd_valid_q, rx_done_q, empty_q, full_q;
    logic          par_err_q, frm_err_q, ovf_q;
    logic          store, accept, full_now, wr_en, rd_go;

    assign store    = (state_q == S_STORE);
    assign accept   = store && !frm_q;
    // Fullness is judged on the registered count, before any same-cycle read.
    assign full_now = (count_q == DEPTH_C);
    assign wr_en    = accept && !full_now && !i_flush;
    assign rd_go    = i_rd_en && (count_q != '0) && !i_flush;

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else begin
            case ({wr_en, rd_go})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (rd_go) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
            end
            if (rd_go) begin
                rd_data_q <= mem[rd_ptr_q];
            end
            rd_valid_q <= rd_go;
            rx_done_q  <= accept;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            // A flag raised in the same cycle as a clear survives.
            par_err_q  <= (accept && par_q)    || (par_err_q && !i_clr_err);
            frm_err_q  <= (store && frm_q)     || (frm_err_q && !i_clr_err);
            ovf_q      <= (accept && full_now) || (ovf_q && !i_clr_err);
        end
    end

    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_count      = count_q;
    assign o_empty      = empty_q;
    assign o_full       = full_q;
    assign o_rx_done    = rx_done_q;
    assign o_parity_err = par_err_q;
    assign o_frame_err  = frm_err_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_capture_buffer
//
// Two instances at DIV=10, LSB first, idle high, depth 4:
//   dut_a : 8N1, used for capture, wrap, overflow, errors, flush, reset and
//           a randomized frame/read phase.
//   dut_b : 8E1, used for the parity check.
// Reference model: a queue of stored bytes plus sticky flag bits, updated
// per frame from the frame-level rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_capture_buffer;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;   // active-high reset
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1;
    logic en = 1'b1, flush = 1'b0, clr = 1'b0, rd_a = 1'b0, rd_b = 1'b0;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic [2:0] count_a, count_b;
    logic       empty_a, empty_b, full_a, full_b, done_a, done_b;
    logic       perr_a, perr_b, ferr_a, ferr_b, ovf_a, ovf_b;
    logic [2:0] dbg_a, dbg_b;

    uart_rx_capture_buffer #(
        .G_BUFFER_ADDR_WIDTH(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_rx(rx_a), .i_enable(en),
        .i_flush(flush), .i_clr_err(clr), .i_rd_en(rd_a),
        .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .o_count(count_a),
        .o_empty(empty_a), .o_full(full_a), .o_rx_done(done_a),
        .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overflow(ovf_a),
        .o_dbg_state(dbg_a)
    );

    uart_rx_capture_buffer #(
        .G_PARITY(1),
        .G_BUFFER_ADDR_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_rx(rx_b), .i_enable(en),
        .i_flush(flush), .i_clr_err(clr), .i_rd_en(rd_b),
        .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .o_count(count_b),
        .o_empty(empty_b), .o_full(full_b), .o_rx_done(done_b),
        .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overflow(ovf_b),
        .o_dbg_state(dbg_b)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic       m_par = 1'b0, m_frm = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_last_rd = 8'h00;
    int         done_exp = 0;
    int         done_cnt_a = 0;

    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive a line level for n clocks; called on a falling edge.
    task automatic line(input bit sel, input bit v, input int n);
        if (sel) rx_b = v; else rx_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data,
                              input bit with_par, input bit pbit, input bit bad_stop);
        line(sel, 1'b0, DIV);
        for (int i = 0; i < 8; i++) line(sel, data[i], DIV);
        if (with_par) line(sel, pbit, DIV);
        if (bad_stop) begin
            // Low long enough to cover the mid-bit sample, then idle again.
            line(sel, 1'b0, 7);
            line(sel, 1'b1, 13);
        end else begin
            line(sel, 1'b1, DIV);
        end
        line(sel, 1'b1, DIV);
    endtask

    task automatic model_frame(input logic [7:0] data, input bit bad_stop);
        if (bad_stop) begin
            m_frm = 1'b1;
        end else begin
            done_exp++;
            if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(data);
        end
    endtask

    task automatic tx_a(input logic [7:0] data, input bit bad_stop);
        send_frame(1'b0, data, 1'b0, 1'b0, bad_stop);
        model_frame(data, bad_stop);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count_a), 32'(exp_q.size()));
        check({tag, ".empty"}, 32'(empty_a), 32'(exp_q.size() == 0));
        check({tag, ".full"},  32'(full_a),  32'(exp_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(ovf_a),   32'(m_ovf));
        check({tag, ".ferr"},  32'(ferr_a),  32'(m_frm));
        check({tag, ".perr"},  32'(perr_a),  32'(m_par));
        check({tag, ".done"},  32'(done_cnt_a), 32'(done_exp));
    endtask

    task automatic read_a(input string tag);
        @(negedge clk);
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        if (exp_q.size() != 0) begin
            m_last_rd = exp_q.pop_front();
            check({tag, ".valid"}, 32'(rd_valid_a), 32'd1);
        end else begin
            check({tag, ".valid"}, 32'(rd_valid_a), 32'd0);
        end
        check({tag, ".data"}, 32'(rd_data_a), 32'(m_last_rd));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(rd_valid_a), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit hit;
        logic [7:0] d;
        bit bad;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst.count", 32'(count_a), 32'd0);
        check("rst.empty", 32'(empty_a), 32'd1);
        check("rst.full",  32'(full_a),  32'd0);
        check("rst.valid", 32'(rd_valid_a), 32'd0);
        check("rst.data",  32'(rd_data_a),  32'd0);
        check("rst.done",  32'(done_a),  32'd0);
        check("rst.flags", 32'({perr_a, ferr_a, ovf_a}), 32'd0);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);

        // Basic capture
        tx_a(8'hA5, 1'b0);
        check_state("basic");
        read_a("basic.rd");
        check_state("basic.after");

        // Read while empty: dropped, data holds
        read_a("empty.rd");

        // Burst and wrap
        for (int i = 1; i <= 3; i++) tx_a(8'(i), 1'b0);
        read_a("wrap.rd0");
        read_a("wrap.rd1");
        for (int i = 4; i <= 6; i++) tx_a(8'(i), 1'b0);
        check_state("wrap");
        for (int i = 0; i < 4; i++) read_a("wrap.rd");
        check_state("wrap.drained");

        // Overflow
        for (int i = 0; i < 5; i++) tx_a(8'(8'h10 + i), 1'b0);
        check_state("ovf");
        for (int i = 0; i < 4; i++) read_a("ovf.rd");
        pulse_clr();
        check_state("ovf.clr");

        // Framing error: not stored, no done pulse
        tx_a(8'h55, 1'b1);
        check_state("frame");
        pulse_clr();

        // Glitch shorter than half a bit
        line(1'b0, 1'b0, 3);
        line(1'b0, 1'b1, 12 * DIV);
        check_state("glitch");

        // Read in the STORE cycle with two words stored, then flush
        tx_a(8'h21, 1'b0);
        tx_a(8'h22, 1'b0);
        hit = 1'b0;
        fork
            send_frame(1'b0, 8'h23, 1'b0, 1'b0, 1'b0);
            begin
                for (int c = 0; c < 200 && !hit; c++) begin
                    @(negedge clk);
                    if (dbg_a == 3'd5) begin
                        rd_a = 1'b1;
                        @(negedge clk);
                        rd_a = 1'b0;
                        hit = 1'b1;
                        check("rw.valid", 32'(rd_valid_a), 32'd1);
                        check("rw.data",  32'(rd_data_a), 32'(exp_q.pop_front()));
                        check("rw.count", 32'(count_a), 32'd2);
                    end
                end
            end
        join
        check("rw.store_seen", 32'(hit), 32'd1);
        exp_q.push_back(8'h23);
        done_exp++;
        check_state("rw");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        check_state("flush");

        // Enable gates only new start bits
        en = 1'b0;
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        check_state("disabled");
        en = 1'b1;
        fork
            send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
            begin
                repeat (30) @(negedge clk);
                en = 1'b0;
            end
        join
        model_frame(8'h3C, 1'b0);
        en = 1'b1;
        check_state("en_mid");

        // Reset in the middle of a frame
        tx_a(8'h11, 1'b0);
        line(1'b0, 1'b0, DIV);
        for (int i = 0; i < 4; i++) line(1'b0, i[0], DIV);
        rx_a = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst.count", 32'(count_a), 32'd0);
        check("mrst.empty", 32'(empty_a), 32'd1);
        check("mrst.full",  32'(full_a),  32'd0);
        check("mrst.data",  32'(rd_data_a), 32'd0);
        check("mrst.valid", 32'(rd_valid_a), 32'd0);
        check("mrst.flags", 32'({perr_a, ferr_a, ovf_a, done_a}), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        m_par = 1'b0; m_frm = 1'b0; m_ovf = 1'b0; m_last_rd = 8'h00;
        line(1'b0, 1'b1, 12 * DIV);
        check_state("mrst.idle");
        tx_a(8'h5A, 1'b0);
        check_state("mrst.cap");
        read_a("mrst.rd");

        // Randomized frames, reads and clears
        for (int it = 0; it < 40; it++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            tx_a(d, bad);
            check_state("rnd");
            for (int r = $urandom_range(0, 2); r > 0; r--) read_a("rnd.rd");
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end
        while (exp_q.size() != 0) read_a("rnd.drain");
        check_state("rnd.end");

        // Even parity on dut_b: correct parity, then wrong parity bit
        d = 8'h03;
        send_frame(1'b1, d, 1'b1, ^d, 1'b0);
        check("par.ok.count", 32'(count_b), 32'd1);
        check("par.ok.perr",  32'(perr_b),  32'd0);
        send_frame(1'b1, d, 1'b1, 1'b1, 1'b0);
        check("par.bad.count", 32'(count_b), 32'd2);
        check("par.bad.perr",  32'(perr_b),  32'd1);
        check("par.bad.ferr",  32'(ferr_b),  32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rd_b = 1'b1;
            @(negedge clk);
            rd_b = 1'b0;
            check("par.rd.valid", 32'(rd_valid_b), 32'd1);
            check("par.rd.data",  32'(rd_data_b),  32'h03);
        end
        @(negedge clk);
        check("par.empty", 32'(empty_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

endmodule
